// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO. It supports any power-of-two depth and
// every entry is usable. Either first-word-fall-through or registered-read
// output can be selected. It provides almost-full and almost-empty flags,
// sticky overflow and underflow flags, and a synchronous flush.
module fifo_sync_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter bit          FWFT     = 1'b1
) (
    input  logic                     CLK,
    input  logic                     rst_in,
    input  logic [WIDTH-1:0]         datain,
    input  logic                     wr_in,
    input  logic                     rd_in,
    input  logic                     flush_in,
    input  logic                     clr_err_in,
    output logic [WIDTH-1:0]         dataout,
    output logic                     full_out,
    output logic                     empty_out,
    output logic                     almost_full_out,
    output logic                     almost_empty_out,
    output logic [$clog2(DEPTH):0]   fill_lvl_out,
    output logic                     overflow_out,
    output logic                     underflow_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_TH = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_TH = AE_LEVEL[AW:0];

    // Pointers carry an extra wrap bit above the address bits.
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic [WIDTH-1:0] mem [DEPTH];

    logic rd_acc;
    logic wr_acc;
    logic ovf_set;
    logic unf_set;

    // Every flag is derived directly from the registered pointers.
    assign empty_out        = (wp == rp);
    assign full_out         = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign fill_lvl_out     = wp - rp;
    assign almost_full_out  = (fill_lvl_out >= AF_TH);
    assign almost_empty_out = (fill_lvl_out <= AE_TH);

    // A write into a full FIFO is accepted when a read frees a slot in the same cycle.
    assign rd_acc  = rd_in & ~empty_out;
    assign wr_acc  = wr_in & (~full_out | rd_acc);
    assign ovf_set = wr_in & ~wr_acc & ~flush_in;
    assign unf_set = rd_in & ~rd_acc & ~flush_in;

    // Storage array. It has no reset, and a flush suppresses the write.
    always_ff @(posedge CLK) begin
        if (wr_acc && !flush_in) begin
            mem[wp[AW-1:0]] <= datain;
        end
    end

    // Pointer update. A flush overrides any read or write in the same cycle.
    always_ff @(posedge CLK or negedge rst_in) begin
        if (!rst_in) begin
            wp <= '0;
            rp <= '0;
        end else if (flush_in) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_acc) begin
                wp <= wp + 1'b1;
            end
            if (rd_acc) begin
                rp <= rp + 1'b1;
            end
        end
    end

    // Sticky error flags. A new error beats a clear in the same cycle.
    always_ff @(posedge CLK or negedge rst_in) begin
        if (!rst_in) begin
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_out <= 1'b1;
            end else if (clr_err_in) begin
                overflow_out <= 1'b0;
            end
            if (unf_set) begin
                underflow_out <= 1'b1;
            end else if (clr_err_in) begin
                underflow_out <= 1'b0;
            end
        end
    end

    if (FWFT) begin : g_fwft
        assign dataout = mem[rp[AW-1:0]];
    end else begin : g_reg
        // Registered read data. It is loaded only on an accepted read and holds otherwise.
        always_ff @(posedge CLK or negedge rst_in) begin
            if (!rst_in) begin
                dataout <= '0;
            end else if (rd_acc && !flush_in) begin
                dataout <= mem[rp[AW-1:0]];
            end
        end
    end

endmodule
